// File: rtl/matrices_pkg.sv
// Shared types and constants for the matrix-vector sequencer: FSM states,
// beat geometry, accumulator width and the per-beat pipeline tag.
package matrices_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 7;
  localparam int N         = 2 ** ADDR_W;
  localparam int BEAT      = 8;
  localparam int LANES     = BEAT / 2;
  localparam int SUM_WIDTH = 2 * DATA_W + $clog2(BEAT);
  localparam int ACC_WIDTH = 2 * DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Travels alongside each address beat until its data reaches the multipliers.
  typedef struct packed {
    logic              valid;
    logic              first;
    logic              last;
    logic [ADDR_W-1:0] row;
  } tag_t;

endpackage

// File: rtl/dot8_sum.sv
// Combinational sum of eight unsigned products: lanes 0..3 of the low buses
// plus lanes 0..3 of the high buses.
module dot8_sum #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int SUM_WIDTH  = 2 * DATA_WIDTH + 3
) (
  input  logic [LANES*DATA_WIDTH-1:0] a_lo,
  input  logic [LANES*DATA_WIDTH-1:0] a_hi,
  input  logic [LANES*DATA_WIDTH-1:0] b_lo,
  input  logic [LANES*DATA_WIDTH-1:0] b_hi,
  output logic [SUM_WIDTH-1:0]        sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum
          + SUM_WIDTH'(a_lo[i*DATA_WIDTH +: DATA_WIDTH]) * SUM_WIDTH'(b_lo[i*DATA_WIDTH +: DATA_WIDTH])
          + SUM_WIDTH'(a_hi[i*DATA_WIDTH +: DATA_WIDTH]) * SUM_WIDTH'(b_hi[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
// Walks the matrix ROM wrapper row by row, accumulates each row's dot product
// from the returned element buses and checks it against the expected-result ROM.
module matvec_sequencer
  import matrices_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int ROM_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic [2*ADDR_WIDTH-1:0]   romA_addrA,
  output logic [2*ADDR_WIDTH-1:0]   romA_addrB,
  output logic [ADDR_WIDTH-1:0]     romB_addrA,
  output logic [ADDR_WIDTH-1:0]     romB_addrB,
  output logic [ADDR_WIDTH-1:0]     romC_addrA,
  output logic [ADDR_WIDTH-1:0]     romC_addrB,
  input  logic [4*DATA_WIDTH-1:0]   romA_busA,
  input  logic [4*DATA_WIDTH-1:0]   romA_busB,
  input  logic [4*DATA_WIDTH-1:0]   romB_busA,
  input  logic [4*DATA_WIDTH-1:0]   romB_busB,
  input  logic [2*DATA_WIDTH-1:0]   romC_dataA,
  output logic                      busy,
  output logic                      result_valid,
  output logic [ADDR_WIDTH-1:0]     result_row,
  output logic [2*DATA_WIDTH-1:0]   result_value,
  output logic                      result_match,
  output logic [7:0]                error_count,
  output logic                      done,
  output logic                      pass,
  output state_t                    fsm_state
);

  localparam int BEAT_BITS = ADDR_WIDTH - $clog2(BEAT);

  state_t                 state, state_next;
  logic [ADDR_WIDTH-1:0]  row_q, row_n;
  logic [BEAT_BITS-1:0]   beat_q, beat_n;
  logic                   load_beat;
  logic                   start_accept;
  logic                   pipe_busy;
  tag_t                   issue_tag;
  tag_t                   pipe [ROM_LATENCY];
  tag_t                   data_tag;
  logic [SUM_WIDTH-1:0]   beat_sum;
  logic [ACC_WIDTH-1:0]   acc, final_sum;
  logic                   mismatch;

  assign fsm_state    = state;
  assign busy         = (state != IDLE);
  assign romC_addrB   = '0;
  assign start_accept = (state == IDLE) && start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_beat  = 1'b0;
    row_n      = row_q;
    beat_n     = beat_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          load_beat  = 1'b1;
          row_n      = '0;
          beat_n     = '0;
        end
      end
      ISSUE: begin
        if (&row_q && &beat_q) begin
          state_next = DRAIN;
        end else begin
          load_beat = 1'b1;
          beat_n    = beat_q + 1'b1;
          if (&beat_q) row_n = row_q + 1'b1;
        end
      end
      DRAIN: begin
        if (done && !pipe_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address registers always hold the beat currently presented to the ROMs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q      <= '0;
      beat_q     <= '0;
      romA_addrA <= '0;
      romA_addrB <= '0;
      romB_addrA <= '0;
      romB_addrB <= '0;
      romC_addrA <= '0;
    end else if (load_beat) begin
      row_q      <= row_n;
      beat_q     <= beat_n;
      romA_addrA <= {row_n, beat_n, 3'b000};
      romA_addrB <= {row_n, beat_n, 3'b100};
      romB_addrA <= {beat_n, 3'b000};
      romB_addrB <= {beat_n, 3'b100};
      if (&beat_n) romC_addrA <= row_n;
    end
  end

  always_comb begin
    issue_tag.valid = (state == ISSUE);
    issue_tag.first = (beat_q == '0);
    issue_tag.last  = &beat_q;
    issue_tag.row   = row_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= issue_tag;
      for (int i = 1; i < ROM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < ROM_LATENCY; i++) pipe_busy = pipe_busy | pipe[i].valid;
  end

  assign data_tag = pipe[ROM_LATENCY-1];

  dot8_sum #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .SUM_WIDTH  (SUM_WIDTH)
  ) u_dot8_sum (
    .a_lo (romA_busA),
    .a_hi (romA_busB),
    .b_lo (romB_busA),
    .b_hi (romB_busB),
    .sum  (beat_sum)
  );

  // The first beat of a row restarts the sum instead of adding to the old row.
  assign final_sum = (data_tag.first ? '0 : acc) + ACC_WIDTH'(beat_sum);
  assign mismatch  = (final_sum[2*DATA_WIDTH-1:0] != romC_dataA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      result_valid <= 1'b0;
      result_row   <= '0;
      result_value <= '0;
      result_match <= 1'b0;
      error_count  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      if (start_accept) begin
        error_count <= '0;
        pass        <= 1'b0;
      end
      if (data_tag.valid) begin
        acc <= final_sum;
        if (data_tag.last) begin
          result_valid <= 1'b1;
          result_row   <= data_tag.row;
          result_value <= final_sum[2*DATA_WIDTH-1:0];
          result_match <= !mismatch;
          if (mismatch) error_count <= error_count + 8'd1;
          if (&data_tag.row) begin
            done <= 1'b1;
            pass <= (error_count == 8'd0) && !mismatch;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Bench for matvec_sequencer: emulates the 2-cycle ROM wrapper from arrays and
// checks addresses, per-row results, counters and pulses against a row-sum model.
module tb_matvec_sequencer;
  import matrices_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] romA_addrA, romA_addrB;
  logic [6:0]  romB_addrA, romB_addrB, romC_addrA, romC_addrB;
  logic [31:0] romA_busA, romA_busB, romB_busA, romB_busB;
  logic [15:0] romC_dataA;
  logic        busy, result_valid, result_match, done, pass;
  logic [6:0]  result_row;
  logic [15:0] result_value;
  logic [7:0]  error_count;
  state_t      fsm_state;

  matvec_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .romA_addrA   (romA_addrA),
    .romA_addrB   (romA_addrB),
    .romB_addrA   (romB_addrA),
    .romB_addrB   (romB_addrB),
    .romC_addrA   (romC_addrA),
    .romC_addrB   (romC_addrB),
    .romA_busA    (romA_busA),
    .romA_busB    (romA_busB),
    .romB_busA    (romB_busA),
    .romB_busB    (romB_busB),
    .romC_dataA   (romC_dataA),
    .busy         (busy),
    .result_valid (result_valid),
    .result_row   (result_row),
    .result_value (result_value),
    .result_match (result_match),
    .error_count  (error_count),
    .done         (done),
    .pass         (pass),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- ROM wrapper model ----------------
  logic [7:0]  mem_a [0:16383];
  logic [7:0]  mem_b [0:127];
  logic [15:0] mem_c [0:127];
  logic [13:0] a_a_s, a_b_s;
  logic [6:0]  b_a_s, b_b_s, c_s;

  function automatic logic [31:0] pack_a(input logic [13:0] base);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = mem_a[int'(base) + i];
    return v;
  endfunction

  function automatic logic [31:0] pack_b(input logic [6:0] base);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = mem_b[int'(base) + i];
    return v;
  endfunction

  always @(posedge clock) begin
    a_a_s      <= romA_addrA;
    a_b_s      <= romA_addrB;
    b_a_s      <= romB_addrA;
    b_b_s      <= romB_addrB;
    c_s        <= romC_addrA;
    romA_busA  <= pack_a(a_a_s);
    romA_busB  <= pack_a(a_b_s);
    romB_busA  <= pack_b(b_a_s);
    romB_busB  <= pack_b(b_b_s);
    romC_dataA <= mem_c[c_s];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [23:0] exp_q[$];   // {row[6:0], value[15:0], match}
  int          exp_err;
  int          vectors;
  int          miscompares;

  function automatic logic [15:0] row_sum(input int r);
    int s;
    s = 0;
    for (int k = 0; k < 128; k++) s += int'(mem_a[r*128 + k]) * int'(mem_b[k]);
    return s[15:0];
  endfunction

  task automatic build_expected();
    logic [15:0] v;
    logic        m;
    exp_q.delete();
    exp_err = 0;
    for (int r = 0; r < 128; r++) begin
      v = row_sum(r);
      m = (v == mem_c[r]);
      exp_q.push_back({7'(r), v, m});
      if (!m) exp_err++;
    end
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    for (int i = 0; i < 16384; i++) mem_a[i] = a;
    for (int i = 0; i < 128; i++) begin
      mem_b[i] = b;
      mem_c[i] = c;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_addrAa"}, 32'(romA_addrA), 0);
    check({tag, "_addrAb"}, 32'(romA_addrB), 0);
    check({tag, "_addrBa"}, 32'(romB_addrA), 0);
    check({tag, "_addrBb"}, 32'(romB_addrB), 0);
    check({tag, "_addrCa"}, 32'(romC_addrA), 0);
    check({tag, "_addrCb"}, 32'(romC_addrB), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_rvalid"}, 32'(result_valid), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_pass"},   32'(pass), 0);
    check({tag, "_errcnt"}, 32'(error_count), 0);
  endtask

  // One full run: start pulse, then per-cycle checks from t0+1 to t0+2060.
  // restart_at re-pulses start in that cycle; abort_at leaves mid-run.
  task automatic run_product(input int restart_at, input int abort_at);
    int          beat, r, kk, err_so_far;
    logic        rv;
    logic [23:0] e;
    build_expected();
    err_so_far = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    for (int j = 1; j <= 2060; j++) begin
      if (j <= 2048) begin
        beat = j - 1;
        r    = beat / 16;
        kk   = (beat % 16) * 8;
        check("addrAa", 32'(romA_addrA), r*128 + kk);
        check("addrAb", 32'(romA_addrB), r*128 + kk + 4);
        check("addrBa", 32'(romB_addrA), kk);
        check("addrBb", 32'(romB_addrB), kk + 4);
        if (kk == 120) check("addrCa", 32'(romC_addrA), r);
      end else begin
        check("hold_addrAa", 32'(romA_addrA), 127*128 + 120);
        check("hold_addrCa", 32'(romC_addrA), 127);
      end
      check("busy", 32'(busy), (j <= 2051) ? 1 : 0);
      rv = (j >= 19) && (j <= 2051) && ((j - 3) % 16 == 0);
      check("rvalid", 32'(result_valid), 32'(rv));
      if (rv) begin
        e = exp_q.pop_front();
        check("rrow",   32'(result_row),   32'(e[23:17]));
        check("rvalue", 32'(result_value), 32'(e[16:1]));
        check("rmatch", 32'(result_match), 32'(e[0]));
        if (!e[0]) err_so_far++;
      end
      check("errcnt", 32'(error_count), err_so_far);
      check("done", 32'(done), (j == 2051) ? 1 : 0);
      check("pass", 32'(pass), (j >= 2051 && exp_err == 0) ? 1 : 0);
      start = (j == restart_at);
      if (j == abort_at) begin
        start = 1'b0;
        return;
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("final_errcnt", 32'(error_count), exp_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    fill(8'd1, 8'd1, 16'h0080);
    repeat (3) @(negedge clock);
    check_quiet("por");
    reset = 1'b0;
    @(negedge clock);
    check_quiet("idle");

    // all-ones product, every row 0x0080
    run_product(0, 0);

    // pass held while idle, then an async reset in the middle of idle
    repeat (3) @(negedge clock);
    check("idle_pass", 32'(pass), 1);
    #2 reset = 1'b1;
    #1 check_quiet("idle_rst");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_quiet("idle_rel");

    // single wrong expectation on row 5
    mem_c[5] = 16'h0081;
    run_product(0, 0);

    // largest elements: 128*255*255 = 0x7F0080
    fill(8'hff, 8'hff, 16'h0080);
    run_product(0, 0);

    // start re-pulsed while busy has no effect
    fill(8'd1, 8'd1, 16'h0080);
    run_product(100, 0);

    // async reset while row 40 is issuing, then a clean restart
    run_product(0, 40*16 + 5);
    #2 reset = 1'b1;
    #1 check_quiet("run_rst");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("post_rst_rvalid", 32'(result_valid), 0);
      check("post_rst_busy", 32'(busy), 0);
    end
    run_product(0, 0);

    // random data with a few corrupted expectations; start coincides with done
    for (int i = 0; i < 16384; i++) mem_a[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 128; i++) mem_b[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 128; r++) begin
      mem_c[r] = row_sum(r);
      if ($urandom_range(0, 5) == 0) mem_c[r] = mem_c[r] ^ 16'(1 << $urandom_range(0, 15));
    end
    run_product(2051, 0);
    repeat (3) @(negedge clock);
    check("end_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
Controls and checks the matrix-vector product C = A x B held in the matrix ROM wrapper (ROM A 128x128 8-bit, ROM B 128x8-bit vector, ROM C 128x16-bit expected results).
- Drives all ROM addresses and consumes the 4-element buses returned 2 cycles later.
- Multiplies and accumulates 8 elements per cycle and compares each row sum against ROM C.
- Sits directly around the wrapper: feeds its address inputs and consumes its data outputs.

Parameters:
DATA_WIDTH, 8, element width of A and B; C width is 2*DATA_WIDTH
ADDR_WIDTH, 7, log2 of matrix dimension N (N = 2**ADDR_WIDTH = 128); ROM A address is 2*ADDR_WIDTH
ROM_LATENCY, 2, cycles from address output to data at inputs (ROM register + wrapper output register)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to run the full product; ignored while busy
romA_addrA, romA_addrB  out  2*ADDR_WIDTH  ROM A base addresses; port A covers elements k..k+3, port B covers k+4..k+7
romB_addrA, romB_addrB  out  ADDR_WIDTH  ROM B base addresses: k and k+4
romC_addrA  out  ADDR_WIDTH  row index of the expected result
romC_addrB  out  ADDR_WIDTH  tied to 0
romA_busA, romA_busB, romB_busA, romB_busB  in  4 x DATA_WIDTH  element vectors; element [i] = base+i
romC_dataA  in  2*DATA_WIDTH  expected row result; romC_dataB unused
busy  out  1  run in progress
result_valid  out  1  one-cycle pulse per completed row
result_row  out  ADDR_WIDTH  row index of the result
result_value  out  2*DATA_WIDTH  low 16 bits of the row sum
result_match  out  1  result_value == expected
error_count  out  8  mismatches in the current run
done  out  1  one-cycle pulse on the final row result
pass  out  1  done seen with error_count == 0; held until the next start or reset

Behaviour:
- Async reset:
  - All outputs go to 0; state goes to IDLE.
  - The in-flight valid pipeline and accumulator are cleared; in-flight beats are discarded.
- State machine:
  - IDLE: start=1 goes to ISSUE. It also clears error_count and pass, and sets row=0, k=0.
  - ISSUE: one address beat per cycle.
    - romA_addrA = row*N + k; romA_addrB = row*N + k + 4; romB_addrA = k; romB_addrB = k + 4.
    - k steps by 8 from 0 to N-8 (16 beats per row), then row increments.
    - On the last beat (k = N-8), romC_addrA = row; otherwise romC_addrA holds its value.
    - After the beat with row = N-1 and k = N-8, go to DRAIN.
  - DRAIN: no new addresses; address outputs hold their last values. Wait until the valid pipeline is empty and the final result has issued, then go to IDLE.
- Address outputs are registered: start sampled at edge t0 means the first addresses appear in cycle t0+1.
- Valid pipeline:
  - ROM_LATENCY-deep shift register carries {valid, first_of_row, last_of_row, row} per beat.
  - Data for a beat issued in cycle t is valid at the inputs in cycle t+ROM_LATENCY.
- Arithmetic:
  - Eight unsigned DATA_WIDTH x DATA_WIDTH products are summed per beat (19-bit).
  - The accumulator is 2*DATA_WIDTH+ADDR_WIDTH = 23 bits. It loads the beat sum on first_of_row and adds the beat sum otherwise.
  - No overflow is possible: 128*255*255 < 2^23.
- Compare: on the last_of_row beat, final = acc + beat_sum is computed combinationally. The following are registered:
  - result_value = final[15:0]
  - result_match = (final[15:0] == romC_dataA)
  - result_row
  - result_valid = 1
- Latency: result_valid rises ROM_LATENCY+1 = 3 cycles after the cycle presenting that row's last address beat.
- error_count increments in the result_valid cycle when result_match = 0. Maximum is 128, so no saturation is needed.
- busy is 1 from cycle t0+1 through the done cycle inclusive.
- done pulses with result_valid for row N-1. pass is set in that same cycle if the final error_count is 0.
- A run takes N*N/8 = 2048 issue cycles. done occurs in cycle t0+2048+3.
- start while busy: ignored, with no effect on addresses or counters.
- Simultaneous done and start: start is ignored because busy is still 1.

Decomposition:
- Shared package matrices_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN)
  - N and the beat size BEAT=8
  - ACC_WIDTH
  - the pipeline-tag struct {valid, first, last, row}
- Sub-module dot8_sum: combinational sum of 8 unsigned products from the four buses (19-bit result). Everything else stays in matvec_sequencer.

Test Plan:
1. Assert reset mid-idle -> all addresses, busy, done, pass, and error_count are 0 while reset is high and after release.
2. Pulse start with A=1, B=1, C=0x0080 -> addresses run (A:0/4, B:0/4), then (8/12, 8/12), …; row 1 starts at A=128/132. 128 result_valid pulses with result_value=0x0080 and match=1; done at t0+2051; pass=1; error_count=0.
3. As scenario 2 with C[5]=0x0081 -> row 5 result_match=0; error_count=1 at done; pass=0.
4. A=255, B=255, C=0x0080 -> sum 8,323,200 (0x7F0080); result_value=0x0080 on every row; all rows match.
5. Pulse start again in cycle t0+100 -> no change to the address sequence or counters; done still at t0+2051.
6. Assert async reset while row 40 is issuing, then restart -> outputs are 0 immediately; no stale result_valid appears; the new run begins at addresses 0/4 with error_count starting from 0.
